fib_gen_bcd: RTL
================

# fib_gen_bcd

Sequential Fibonacci sequence generator producing terms F(0), F(1), F(2)… as packed BCD, one term per valid/ready handshake. It is the source-side counterpart of the BCD Fibonacci recognizer: it generates the numbers the recognizer classifies, so one can feed the other in lab benches and on-board demos (display driver downstream). Addition is digit-serial through a single BCD digit adder. Generation stops after a requested term count or when the next term no longer fits in DIGITS BCD digits.

## Interface
- DIGITS, default 4: number of BCD digits per term; output width 4*DIGITS.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- n_terms  in  8  number of terms to emit; captured on accepted start.
- out_bcd  out  4*DIGITS  current term, packed BCD, digit 0 in bits [3:0].
- out_valid  out  1  out_bcd holds a term.
- out_ready  in  1  consumer accepts term when high with out_valid.
- out_last  out  1  current term is the final one; qualified by out_valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a sequence ends.
- overflow  out  1  sticky: the sequence ended early because the next term overflowed; cleared on accepted start or reset.

## Operation
- Registers: a (current term), b (next term), b_ovf, cnt (terms emitted), n_lat (captured n_terms), digit index for ADD.
- States: IDLE, EMIT, ADD, FIN.
- IDLE: on start: a=0, b=1, b_ovf=0, cnt=0, n_lat=n_terms, overflow=0; go to EMIT if n_terms!=0, else FIN. start is ignored in all other states.
- EMIT: out_valid=1, out_bcd=a, out_last=(cnt==n_lat-1) || b_ovf. On out_valid&&out_ready: if out_last go to FIN (overflow=1 if b_ovf and cnt!=n_lat-1), else cnt++ and go to ADD.
- ADD: exactly DIGITS cycles; cycle k adds digit k of a, digit k of b and the carry, writes digit k of sum (digit result >9 corrected by +6, carry out). After the last digit: a<=b, b<=sum, b_ovf<=final carry; go to EMIT.
- FIN: done=1 for one cycle, go to IDLE.
- Arithmetic: operands always valid BCD; no binary intermediate values; carry out of digit DIGITS-1 only sets b_ovf.
- With DIGITS=4: last representable term F(20)=0x6765; F(21)=10946 overflows, so at most 21 terms emitted.

## Timing
- Reset values: out_bcd=0, out_valid=0, out_last=0, busy=0, done=0, overflow=0; state IDLE. Reset at any state, including mid-ADD or EMIT-with-stall, aborts the sequence with no done pulse.
- start sampled at edge t → out_valid=1 with out_bcd=0 from t+1.
- Handshake at edge h (non-last) → out_valid=0 for DIGITS cycles, next term valid from h+DIGITS+1. Minimum term spacing DIGITS+1 cycles.
- out_bcd and out_last held stable while out_valid=1 and out_ready=0; out_valid never drops without a handshake.
- Last handshake at edge h → done=1 during cycle h+1, busy=0 from h+2; new start accepted from h+2.
- n_terms=0: start at t → done=1 during t+1, no out_valid.
- out_ready is ignored when out_valid=0.

## Structure
- Package fib_pkg: state enum (IDLE, EMIT, ADD, FIN), BCD digit width constant 4, bcd_digit_t typedef.
- Sub-module bcd_digit_adder: combinational, inputs two bcd_digit_t and cin, outputs sum digit and cout; single instance reused across ADD cycles.

## Test plan
- Reset, start with n_terms=8, out_ready=1 → terms 0x0000,0x0001,0x0001,0x0002,0x0003,0x0005,0x0008,0x0013; out_last only on 0x0013; done one cycle after; overflow=0; spacing 5 cycles.
- start with n_terms=30 → 21 terms ending 0x6765 with out_last=1; overflow=1 after done; BCD carry checked at 0x0089+0x0144=0x0233.
- Backpressure: hold out_ready=0 for 10 cycles on term 0x0005, pulse on/off randomly → out_bcd constant while stalled, no term dropped or duplicated.
- n_terms=0 → done pulse at t+1, out_valid never asserted; n_terms=1 → single term 0x0000 with out_last=1.
- Reset asserted during second ADD cycle → next cycle all outputs zero, busy=0, no done; restart with n_terms=3 → 0,1,1.
- start asserted while busy → ignored, sequence and n_lat unchanged.

Source files
------------

// File: rtl/fib_gen_bcd_pkg.sv
// Shared types for the BCD Fibonacci generator: FSM states and the BCD digit type.
package fib_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    ADD  = 2'd2,
    FIN  = 2'd3
  } state_t;

  typedef logic [BCD_W-1:0] bcd_digit_t;

endpackage

// File: rtl/fib_gen_bcd_if.sv
// Term output stream of the BCD Fibonacci generator (valid/ready with last marker).
interface fib_gen_bcd_if #(
  parameter int DIGITS = 4
) ();

  logic [4*DIGITS-1:0] out_bcd;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;

  modport master (output out_bcd, output out_valid, output out_last, input out_ready);
  modport slave  (input out_bcd, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/fib_gen_bcd_adder.sv
// Single-digit BCD adder; the generator reuses one instance across every ADD cycle.
module bcd_digit_adder
  import fib_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout
);

  logic [BCD_W:0] raw_s;

  // Binary digit sum, then +6 correction whenever it leaves the 0..9 range
  always_comb begin
    raw_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (raw_s > 5'd9) begin
      sum  = raw_s[BCD_W-1:0] + 4'd6;
      cout = 1'b1;
    end else begin
      sum  = raw_s[BCD_W-1:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/fib_gen_bcd.sv
// BCD Fibonacci term generator: emits F(0), F(1), ... one per handshake, adding digit-serially.
// Stops after n_terms terms or when the next term would need more than DIGITS digits.
module fib_gen_bcd
  import fib_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          n_terms,
  fib_gen_bcd_if.master       out_if,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  localparam int W  = BCD_W * DIGITS;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t            state_r, state_s;
  logic [W-1:0]      a_r, b_r;
  logic [W-BCD_W-1:0] sum_r;
  logic [W-1:0]      sum_w_s;
  logic              b_ovf_r, carry_r, overflow_r;
  logic [7:0]        cnt_r, n_lat_r;
  logic [DW-1:0]     dig_r;
  bcd_digit_t        sum_dig_s;
  logic              cout_s, last_s, hs_s, last_dig_s;

  // a_r and b_r rotate one digit per ADD cycle, so the active digit is always at [3:0]
  bcd_digit_adder u_add (
    .a    (a_r[BCD_W-1:0]),
    .b    (b_r[BCD_W-1:0]),
    .cin  (carry_r),
    .sum  (sum_dig_s),
    .cout (cout_s)
  );

  assign sum_w_s    = {sum_dig_s, sum_r};
  assign last_s     = (cnt_r == (n_lat_r - 8'd1)) || b_ovf_r;
  assign hs_s       = (state_r == EMIT) && out_if.out_ready;
  assign last_dig_s = (dig_r == DW'(DIGITS - 1));

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = (n_terms != 8'd0) ? EMIT : FIN;
        else       state_s = IDLE;
      end
      EMIT: begin
        if (hs_s) state_s = last_s ? FIN : ADD;
        else      state_s = EMIT;
      end
      ADD: begin
        if (last_dig_s) state_s = EMIT;
        else            state_s = ADD;
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Term registers, counters and digit-serial sum accumulation
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r        <= '0;
      b_r        <= '0;
      sum_r      <= '0;
      b_ovf_r    <= 1'b0;
      carry_r    <= 1'b0;
      overflow_r <= 1'b0;
      cnt_r      <= 8'd0;
      n_lat_r    <= 8'd0;
      dig_r      <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r        <= '0;
            b_r        <= W'(1);
            b_ovf_r    <= 1'b0;
            cnt_r      <= 8'd0;
            n_lat_r    <= n_terms;
            overflow_r <= 1'b0;
          end
        end
        EMIT: begin
          if (hs_s) begin
            if (last_s) begin
              if (b_ovf_r && (cnt_r != (n_lat_r - 8'd1))) overflow_r <= 1'b1;
            end else begin
              cnt_r   <= cnt_r + 8'd1;
              dig_r   <= '0;
              carry_r <= 1'b0;
            end
          end
        end
        ADD: begin
          carry_r <= cout_s;
          dig_r   <= dig_r + DW'(1);
          if (last_dig_s) begin
            // b_r has completed its rotation and is back in natural digit order
            a_r     <= {b_r[BCD_W-1:0], b_r[W-1:BCD_W]};
            b_r     <= sum_w_s;
            b_ovf_r <= cout_s;
          end else begin
            a_r   <= {a_r[BCD_W-1:0], a_r[W-1:BCD_W]};
            b_r   <= {b_r[BCD_W-1:0], b_r[W-1:BCD_W]};
            sum_r <= sum_w_s[W-1:BCD_W];
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign out_if.out_valid = (state_r == EMIT);
  assign out_if.out_bcd   = a_r;
  assign out_if.out_last  = (state_r == EMIT) && last_s;
  assign busy             = (state_r != IDLE);
  assign done             = (state_r == FIN);
  assign overflow         = overflow_r;

endmodule
